// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave register file.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_t;

    localparam int          NUM_REGS      = 16;
    localparam int          ADDR_LSB      = 2;
    localparam logic [3:0]  ID_OFFSET     = 4'hF;
    localparam logic [3:0]  STATUS_OFFSET = 4'hE;

endpackage

// File: rtl/apb_prot_checker.sv
// APB protocol violation counter (8-bit, saturating), cleared by a write to the status offset.
module apb_prot_checker
    import apb_slv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           sel,
    input  logic           penable,
    input  logic           pwrite,
    input  logic [31:0]    paddr,
    input  apb_slv_state_t state,
    input  logic           clr,
    output logic [7:0]     count
);

    logic [31:0] paddr_p0;
    logic        pwrite_p0;
    logic        violation;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // state==SETUP means the previous cycle was the setup phase, so *_p0 hold its address/direction
    assign violation = (penable && sel && (state == IDLE))
                    || ((state == SETUP) && !sel)
                    || ((state == SETUP) && ((paddr != paddr_p0) || (pwrite != pwrite_p0)));

    always_ff @(posedge clk) begin
        paddr_p0  <= paddr;
        pwrite_p0 <= pwrite;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (violation) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB2 zero-wait-state slave with 16 x 32-bit registers and a read-only ID word.
// Define APB_SLV_PROT_CHECK_EN to add the protocol checker; its count replaces register 14.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned  SLV_IDX  = 0,
    parameter logic [31:0]  ID_VALUE = 32'hA9B0_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    input  logic [3:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    output logic [31:0] Prdata
);

`ifdef APB_SLV_PROT_CHECK_EN
    localparam int NUM_RW = NUM_REGS - 2;
`else
    localparam int NUM_RW = NUM_REGS - 1;
`endif
    localparam logic [1:0] SEL_BIT = SLV_IDX[1:0];

    apb_slv_state_t state;
    logic [31:0]    regs [NUM_RW];
    logic [31:0]    rd_val;
    logic [3:0]     idx;
    logic           sel;
    logic           in_range;
    logic           wr_commit;
    logic           rd_setup;
    logic           unused_ok;

    assign sel       = Pselx[SEL_BIT];
    assign idx       = Paddr[ADDR_LSB +: 4];
    assign in_range  = (Paddr[31:ADDR_LSB+4] == '0);
    assign wr_commit = sel && Penable && Pwrite && (state == SETUP) && in_range;
    assign rd_setup  = sel && !Penable && !Pwrite;
    assign unused_ok = &{1'b0, Paddr[ADDR_LSB-1:0]};

`ifdef APB_SLV_PROT_CHECK_EN
    logic [7:0] status_cnt;

    apb_prot_checker u_checker (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .penable (Penable),
        .pwrite  (Pwrite),
        .paddr   (Paddr),
        .state   (state),
        .clr     (wr_commit && (idx == STATUS_OFFSET)),
        .count   (status_cnt)
    );
`endif

    always_comb begin
        rd_val = '0;
        if (in_range) begin
            if (idx == ID_OFFSET) begin
                rd_val = ID_VALUE;
            end
`ifdef APB_SLV_PROT_CHECK_EN
            else if (idx == STATUS_OFFSET) begin
                rd_val = {24'h0, status_cnt};
            end
`endif
            else begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (idx == 4'(i)) rd_val = regs[i];
                end
            end
        end
    end

    // Read-only offsets fall outside the loop range, so writes to them never land
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (idx == 4'(i)) regs[i] <= Pwdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            Prdata <= '0;
        end else begin
            Prdata <= rd_setup ? rd_val : '0;
            case (state)
                IDLE:    if (sel && !Penable) state <= SETUP;
                SETUP:   state <= ACCESS;
                ACCESS:  state <= (sel && !Penable) ? SETUP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile (SLV_IDX=2): directed table, corner sequences, random vs model.
module tb_apb_slave_regfile;
    import apb_slv_pkg::*;

    localparam int          SLV   = 2;
    localparam logic [31:0] IDV   = 32'hA9B0_0001;
    localparam logic [3:0]  MYSEL = 4'b0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic [3:0]  Pselx;
    logic        Penable, Pwrite;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [16];
    int          mcount;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    apb_slave_regfile #(.SLV_IDX(SLV), .ID_VALUE(IDV)) dut (
        .clk     (clk),
        .rst     (rst),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Pselx   (Pselx),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Prdata  (Prdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        Pselx   = 4'b0000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
    endtask

    function automatic void model_reset;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mcount = 0;
    endfunction

    function automatic void model_violate;
        if (mcount < 255) mcount++;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a[31:6] != 0) return 32'h0;
        if (a[5:2] == 4'hF) return IDV;
`ifdef APB_SLV_PROT_CHECK_EN
        if (a[5:2] == 4'hE) return 32'(mcount);
`endif
        return mregs[a[5:2]];
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
        if (a[31:6] != 0) return;
        if (a[5:2] == 4'hF) return;
`ifdef APB_SLV_PROT_CHECK_EN
        if (a[5:2] == 4'hE) begin
            mcount = 0;
            return;
        end
`endif
        mregs[a[5:2]] = d;
    endfunction

    task automatic setup(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        Pselx   = s;
        Paddr   = a;
        Pwdata  = d;
        Pwrite  = wr;
        Penable = 1'b0;
        tick;
    endtask

    task automatic access;
        Penable = 1'b1;
        tick;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        setup(wr, a, d, s);
        rd = Prdata;
        access;
        if (wr && s[SLV]) model_wr(a, d);
    endtask

    task automatic idle_chk(input string name);
        drive_idle;
        check(name, Prdata, 32'h0);
        tick;
    endtask

    task automatic read_exp(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, a, 32'h0, MYSEL, rd);
        check(name, rd, exp);
        idle_chk({name, "_next"});
    endtask

    initial begin
        logic [31:0] rd, a, d, exp;
        logic [3:0]  s;
        bit          wr;

        rst = 1'b1;
        Paddr = '0;
        Pwdata = '0;
        drive_idle;
        model_reset;
        tick;
        tick;
        rst = 1'b0;
        check("reset_prdata", Prdata, 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));

        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,          32'h0});
        tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF,   32'h0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,          32'hDEADBEEF});
        tbl.push_back('{1'b0, 32'h0000_003C, 32'h0,          32'hA9B0_0001});
        tbl.push_back('{1'b1, 32'h0000_003C, 32'h0,          32'h0});
        tbl.push_back('{1'b0, 32'h0000_003C, 32'h0,          32'hA9B0_0001});
        tbl.push_back('{1'b1, 32'h0000_0000, 32'hA5A5A5A5,   32'h0});
        tbl.push_back('{1'b1, 32'h0000_0040, 32'h0000_0055,  32'h0});
        tbl.push_back('{1'b0, 32'h0000_0040, 32'h0,          32'h0});
        tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,          32'hA5A5A5A5});
        tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,          32'hDEADBEEF});
        tbl.push_back('{1'b1, 32'h0000_0037, 32'h12345678,   32'h0});
        tbl.push_back('{1'b0, 32'h0000_0034, 32'h0,          32'h12345678});
        tbl.push_back('{1'b0, 32'h8000_0034, 32'h0,          32'h0});
        tbl.push_back('{1'b1, 32'h8000_0000, 32'hFFFFFFFF,   32'h0});
        tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,          32'hA5A5A5A5});
        tbl.push_back('{1'b1, 32'h0000_0038, 32'hCAFEF00D,   32'h0});
`ifdef APB_SLV_PROT_CHECK_EN
        tbl.push_back('{1'b0, 32'h0000_0038, 32'h0,          32'h0});
`else
        tbl.push_back('{1'b0, 32'h0000_0038, 32'h0,          32'hCAFEF00D});
`endif

        foreach (tbl[i]) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, MYSEL, rd);
            check($sformatf("tbl%0d", i), rd, tbl[i].exp);
            idle_chk($sformatf("tbl%0d_next", i));
        end

        // back-to-back writes, then back-to-back reads
        setup(1'b1, 32'h00, 32'h1, MYSEL);
        check("b2b_st0", 32'(dut.state), 32'(SETUP));
        access;
        check("b2b_st1", 32'(dut.state), 32'(ACCESS));
        model_wr(32'h00, 32'h1);
        setup(1'b1, 32'h04, 32'h2, MYSEL);
        check("b2b_st2", 32'(dut.state), 32'(SETUP));
        access;
        check("b2b_st3", 32'(dut.state), 32'(ACCESS));
        model_wr(32'h04, 32'h2);
        setup(1'b0, 32'h00, 32'h0, MYSEL);
        check("b2b_rd0", Prdata, 32'h1);
        access;
        setup(1'b0, 32'h04, 32'h0, MYSEL);
        check("b2b_rd1", Prdata, 32'h2);
        access;
        idle_chk("b2b_rd_next");

        // another slave selected: nothing moves
        setup(1'b1, 32'h00, 32'h0BAD, 4'b0001);
        check("nosel_state", 32'(dut.state), 32'(IDLE));
        access;
        drive_idle;
        tick;
        xfer(1'b0, 32'h00, 32'h0, 4'b0001, rd);
        check("nosel_rd", rd, 32'h0);
        idle_chk("nosel_rd_next");
        read_exp("nosel_keep", 32'h00, 32'h1);

        // Penable without setup: ignored
        Pselx = MYSEL; Paddr = 32'h0C; Pwdata = 32'h77; Pwrite = 1'b1; Penable = 1'b1;
        tick;
        model_violate;
        check("pen_idle_state", 32'(dut.state), 32'(IDLE));
        drive_idle;
        tick;
        read_exp("pen_idle_rd", 32'h0C, 32'h0);

        // reset in the access phase of a write
        setup(1'b1, 32'h08, 32'hFF, MYSEL);
        Penable = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive_idle;
        model_reset;
        check("rst_wr_state", 32'(dut.state), 32'(IDLE));
        check("rst_wr_prdata", Prdata, 32'h0);
        read_exp("rst_wr_rd08", 32'h08, 32'h0);
        read_exp("rst_wr_rd00", 32'h00, 32'h0);

        // reset in the access phase of a read
        xfer(1'b1, 32'h10, 32'h1234, MYSEL, rd);
        drive_idle;
        tick;
        setup(1'b0, 32'h10, 32'h0, MYSEL);
        check("rst_rd_pre", Prdata, 32'h1234);
        Penable = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive_idle;
        model_reset;
        check("rst_rd_prdata", Prdata, 32'h0);
        tick;

`ifdef APB_SLV_PROT_CHECK_EN
        xfer(1'b1, 32'h38, 32'h0, MYSEL, rd);
        drive_idle;
        tick;
        for (int k = 0; k < 2; k++) begin
            Pselx = MYSEL; Penable = 1'b1; Pwrite = 1'b0;
            tick;
            model_violate;
            drive_idle;
            tick;
        end
        read_exp("chk_two", 32'h38, 32'h2);
        xfer(1'b1, 32'h38, 32'h0, MYSEL, rd);
        drive_idle;
        tick;
        read_exp("chk_clr", 32'h38, 32'h0);
        // sel dropped during access, then address changed during access
        setup(1'b0, 32'h00, 32'h0, MYSEL);
        Pselx = 4'b0000;
        Penable = 1'b1;
        tick;
        model_violate;
        drive_idle;
        tick;
        setup(1'b0, 32'h00, 32'h0, MYSEL);
        Paddr = 32'h04;
        access;
        model_violate;
        drive_idle;
        tick;
        read_exp("chk_seldrop_addr", 32'h38, 32'h2);
        Pselx = MYSEL; Penable = 1'b1; Pwrite = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick;
            model_violate;
        end
        drive_idle;
        tick;
        read_exp("chk_sat", 32'h38, 32'hFF);
`endif

        // randomized transfers against the model
        for (int n = 0; n < 400; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {26'h0, 4'($urandom), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a[31:6] = 26'($urandom) | 26'h1;
            d  = $urandom;
            s  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : MYSEL;
            exp = (!wr && s[SLV]) ? model_rd(a) : 32'h0;
            xfer(wr, a, d, s, rd);
            check($sformatf("rnd%0d_%s_%h", n, wr ? "wr" : "rd", a), rd, exp);
            if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rnd%0d_next", n));
        end
        drive_idle;
        tick;
        for (int i = 0; i < 16; i++) begin
            read_exp($sformatf("final_r%0d", i), 32'(i * 4), model_rd(32'(i * 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter SLV_IDX, default 0: the Pselx bit (0..3) that selects this slave.
REQ-002 SHALL have parameter ID_VALUE, default 32'hA9B0_0001: constant returned at offset 0x3C.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Paddr, input, 32 bits: APB address.
REQ-006 SHALL have port Pwdata, input, 32 bits: APB write data.
REQ-007 SHALL have port Pselx, input, 4 bits: APB slave selects; only bit SLV_IDX is used.
REQ-008 SHALL have port Penable, input, 1 bit: APB access-phase strobe.
REQ-009 SHALL have port Pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port Prdata, output, 32 bits: registered APB read data.

Function
REQ-011 SHALL implement APB2 responder behaviour with no wait states and no Pready/Pslverr.
REQ-012 SHALL run a 3-state FSM: IDLE, SETUP, ACCESS.
- sel = Pselx[SLV_IDX].
- IDLE -> SETUP when sel & !Penable.
- SETUP -> ACCESS unconditionally.
- ACCESS -> SETUP when sel & !Penable (back-to-back transfer).
- ACCESS -> IDLE otherwise.
REQ-013 SHALL hold 16 x 32-bit registers, indexed by Paddr[5:2]; Paddr[1:0] SHALL be ignored.
REQ-014 SHALL treat Paddr[31:6] != 0 as out-of-range: reads return 0 and writes are dropped.
REQ-015 SHALL make registers 0..13 read/write; register 15 (0x3C) SHALL be read-only and return ID_VALUE.
REQ-016 SHALL commit a write at the posedge where sel & Penable & Pwrite & state==SETUP, using the Paddr/Pwdata sampled at that edge.
REQ-017 SHALL load Prdata at the posedge where sel & !Penable & !Pwrite, from the register addressed by Paddr, so it is valid throughout the following access cycle.
REQ-018 SHALL drive Prdata to 0 in every cycle other than the one immediately following a read setup edge.
REQ-019 SHALL ignore writes to read-only offsets; such writes SHALL not modify any state.
REQ-020 SHALL ignore Penable high while state==IDLE: no write is committed and the FSM stays IDLE.
REQ-021 SHALL treat a read setup whose address matches a write committed on the same edge as returning the old value; there is no bypass.

Reset
REQ-022 SHALL, on rst high at posedge clk, set the FSM to IDLE, Prdata to 0, and all RW registers to 0; rst SHALL override any transfer in progress.
REQ-023 SHALL abort a transfer interrupted by reset mid-operation: no write is committed, and Prdata reads 0 in the cycle after reset.

Configuration
REQ-024 SHALL compile the protocol checker in when macro APB_SLV_PROT_CHECK_EN is defined.
- An 8-bit saturating violation counter increments by 1 per cycle in which any of these occurs:
- Penable high with state==IDLE and sel high.
- sel drops while state==SETUP.
- Paddr or Pwrite changes between the SETUP and ACCESS cycles.
- Register 14 (0x38) becomes read-only, reads {24'h0, count}, and a write of any value to it clears the count.
REQ-025 SHALL, when APB_SLV_PROT_CHECK_EN is undefined, omit the checker logic entirely and make register 14 ordinary RW.

Structure
REQ-026 SHALL place state enum apb_slv_state_t (IDLE/SETUP/ACCESS), NUM_REGS=16, ADDR_LSB=2, ID_OFFSET=4'hF and STATUS_OFFSET=4'hE in shared package apb_slv_pkg.
REQ-027 SHALL implement the checker of REQ-024 as sub-module apb_prot_checker, instantiated only under APB_SLV_PROT_CHECK_EN.

Verification
REQ-028 SHALL cover write then read: write 0x10 <- 0xDEADBEEF, then read 0x10 -> Prdata = 0xDEADBEEF in the access cycle and 0 in the next cycle.
REQ-029 SHALL cover back-to-back transfers: writes 0x00 <- 1 and 0x04 <- 2 with no idle cycle, then reads -> 1 and 2; FSM path is SETUP, ACCESS, SETUP, ACCESS.
REQ-030 SHALL cover ID and out-of-range access:
- Read 0x3C -> 0xA9B0_0001.
- Write 0x3C <- 0 -> ID unchanged.
- Write 0x40 <- 0x55 -> no register changes; read 0x40 -> 0.
REQ-031 SHALL cover select decode: SLV_IDX=2, transfer with Pselx=4'b0001 -> no state change and Prdata stays 0.
REQ-032 SHALL cover reset mid-transfer: rst asserted in the ACCESS cycle of a write 0x08 <- 0xFF -> register 0x08 reads 0 and FSM is IDLE.
REQ-033 SHALL cover the checker (macro defined): Penable high with no setup, twice -> read 0x38 = 2; write 0x38 -> read 0x38 = 0; 300 violations -> count saturates at 0xFF.
